// File: rtl/collision_pkg.sv
// Collision checker types and constants.
package collision_pkg;
   localparam int unsigned COORD_W        = 13;
   localparam int unsigned DEFAULT_MARGIN = 1;

   typedef enum logic [1:0] {IDLE, SCAN, DONE} state_t;

   typedef struct packed {
      logic signed [COORD_W-1:0] x;
      logic signed [COORD_W-1:0] y;
      logic signed [COORD_W-1:0] w;
      logic signed [COORD_W-1:0] h;
   } box_t;

   // Sign-extend x, zero-extend the unsigned fields into a 13-bit signed box.
   function automatic box_t make_box(input logic signed [10:0] x, input logic [9:0] y,
                                     input logic [9:0] w, input logic [9:0] h);
      box_t b;
      b.x = $signed({{2{x[10]}}, x});
      b.y = $signed({3'b000, y});
      b.w = $signed({3'b000, w});
      b.h = $signed({3'b000, h});
      return b;
   endfunction
endpackage

// File: rtl/horizon_pkg.sv
// Horizon-side constants shared with obstacle consumers.
package horizon_pkg;
   localparam int unsigned MAX_OBSTACLES = 7;
endpackage

// File: rtl/collision_checker_if.sv
// Check request, T-rex box, obstacle slot table and scan result signals.
interface collision_checker_if #(
   parameter int unsigned MAX_OBSTACLES = horizon_pkg::MAX_OBSTACLES,
   parameter int unsigned IDX_W         = 3
);
   logic                     check;
   logic signed [10:0]       trex_x_pos;
   logic [9:0]               trex_y_pos;
   logic [9:0]               trex_width;
   logic [9:0]               trex_height;
   logic [MAX_OBSTACLES-1:0] obstacle_start;
   logic signed [10:0]       obstacle_x_pos  [MAX_OBSTACLES];
   logic [9:0]               obstacle_y_pos  [MAX_OBSTACLES];
   logic [9:0]               obstacle_width  [MAX_OBSTACLES];
   logic [9:0]               obstacle_height [MAX_OBSTACLES];
   logic                     busy;
   logic                     done;
   logic                     crash;
   logic [IDX_W-1:0]         hit_index;

   modport master (
      output check, trex_x_pos, trex_y_pos, trex_width, trex_height,
             obstacle_start, obstacle_x_pos, obstacle_y_pos, obstacle_width, obstacle_height,
      input  busy, done, crash, hit_index
   );

   modport slave (
      input  check, trex_x_pos, trex_y_pos, trex_width, trex_height,
             obstacle_start, obstacle_x_pos, obstacle_y_pos, obstacle_width, obstacle_height,
      output busy, done, crash, hit_index
   );
endinterface

// File: rtl/box_overlap.sv
// Combinational margin-shrunk strict overlap test between two boxes.
module box_overlap
   import collision_pkg::*;
(
   input  box_t                      a,
   input  box_t                      b,
   input  logic signed [COORD_W-1:0] margin,
   output logic                      hit
);
   logic signed [COORD_W-1:0] two_m;
   logic signed [COORD_W-1:0] a_l, a_r, a_t, a_b;
   logic signed [COORD_W-1:0] b_l, b_r, b_t, b_b;
   logic signed [COORD_W-1:0] bw, bh;

   // Shrunk box edges; signed so off-screen-left obstacles compare correctly.
   always_comb begin
      two_m = margin + margin;
      bw    = b.w;
      bh    = b.h;
      a_l   = a.x + margin;
      a_r   = a.x + a.w - margin;
      a_t   = a.y + margin;
      a_b   = a.y + a.h - margin;
      b_l   = b.x + margin;
      b_r   = b.x + b.w - margin;
      b_t   = b.y + margin;
      b_b   = b.y + b.h - margin;
   end

   // Degenerate obstacles vanish after shrinking; touching edges are not a hit.
   always_comb begin
      hit = 1'b0;
      if ((bw > two_m) && (bh > two_m))
         hit = (a_l < b_r) && (b_l < a_r) && (a_t < b_b) && (b_t < a_b);
   end
endmodule

// File: rtl/collision_checker.sv
// Sequential obstacle scanner raising a sticky crash flag on the first overlap.
module collision_checker
   import collision_pkg::*;
#(
   parameter int unsigned MAX_OBSTACLES = horizon_pkg::MAX_OBSTACLES,
   parameter int unsigned MARGIN        = DEFAULT_MARGIN,
   parameter int unsigned IDX_W         = 3
) (
   input logic               clk,
   input logic               rst,
   collision_checker_if.slave bus
);
   localparam logic signed [COORD_W-1:0] MARGIN_S = COORD_W'(MARGIN);
   localparam logic [IDX_W-1:0]          LAST_IDX = IDX_W'(MAX_OBSTACLES - 1);

   state_t           state_q, state_d;
   logic [IDX_W-1:0] idx_q, idx_d;
   box_t             trex_q, trex_d;
   logic             busy_q, busy_d;
   logic             done_q, done_d;
   logic             crash_q, crash_d;
   logic [IDX_W-1:0] hit_index_q, hit_index_d;
   box_t             obs_box;
   logic             obs_start;
   logic             overlap;

   // Select the slot under evaluation from the live obstacle table.
   always_comb begin
      obs_box   = '0;
      obs_start = 1'b0;
      for (int i = 0; i < int'(MAX_OBSTACLES); i++) begin
         if (idx_q == IDX_W'(i)) begin
            obs_box   = make_box(bus.obstacle_x_pos[i], bus.obstacle_y_pos[i],
                                 bus.obstacle_width[i], bus.obstacle_height[i]);
            obs_start = bus.obstacle_start[i];
         end
      end
   end

   box_overlap u_overlap (
      .a      (trex_q),
      .b      (obs_box),
      .margin (MARGIN_S),
      .hit    (overlap)
   );

   // Next-state and next-output logic.
   always_comb begin
      state_d     = state_q;
      idx_d       = idx_q;
      trex_d      = trex_q;
      crash_d     = crash_q;
      hit_index_d = hit_index_q;
      case (state_q)
         IDLE: begin
            if (bus.check && !crash_q) begin
               state_d = SCAN;
               idx_d   = '0;
               trex_d  = make_box(bus.trex_x_pos, bus.trex_y_pos,
                                  bus.trex_width, bus.trex_height);
            end
         end
         SCAN: begin
            if (obs_start && overlap) begin
               crash_d     = 1'b1;
               hit_index_d = idx_q;
               state_d     = DONE;
            end else if (idx_q == LAST_IDX) begin
               state_d = DONE;
            end else begin
               idx_d = idx_q + IDX_W'(1);
            end
         end
         DONE:    state_d = IDLE;
         default: state_d = IDLE;
      endcase
      busy_d = (state_d == SCAN);
      done_d = (state_d == DONE);
   end

   // State and output registers.
   always_ff @(posedge clk) begin
      if (rst) begin
         state_q     <= IDLE;
         idx_q       <= '0;
         trex_q      <= '0;
         busy_q      <= 1'b0;
         done_q      <= 1'b0;
         crash_q     <= 1'b0;
         hit_index_q <= '0;
      end else begin
         state_q     <= state_d;
         idx_q       <= idx_d;
         trex_q      <= trex_d;
         busy_q      <= busy_d;
         done_q      <= done_d;
         crash_q     <= crash_d;
         hit_index_q <= hit_index_d;
      end
   end

   assign bus.busy      = busy_q;
   assign bus.done      = done_q;
   assign bus.crash     = crash_q;
   assign bus.hit_index = hit_index_q;
endmodule

// File: tb/tb_collision_checker.sv
// Directed bench for collision_checker.
module tb_collision_checker;
   localparam int N = 7;

   logic clk = 1'b0;
   logic rst = 1'b1;
   int   errors = 0;
   int   checks = 0;

   always #5 clk = ~clk;

   collision_checker_if bus ();

   collision_checker dut (
      .clk (clk),
      .rst (rst),
      .bus (bus)
   );

   task automatic clear_slots();
      for (int i = 0; i < N; i++) begin
         bus.obstacle_start[i]  = 1'b0;
         bus.obstacle_x_pos[i]  = '0;
         bus.obstacle_y_pos[i]  = '0;
         bus.obstacle_width[i]  = '0;
         bus.obstacle_height[i] = '0;
      end
   endtask

   task automatic set_slot(input int i, input int x, input int y, input int w, input int h);
      bus.obstacle_start[i]  = 1'b1;
      bus.obstacle_x_pos[i]  = 11'(x);
      bus.obstacle_y_pos[i]  = 10'(y);
      bus.obstacle_width[i]  = 10'(w);
      bus.obstacle_height[i] = 10'(h);
   endtask

   task automatic set_trex();
      bus.trex_x_pos  = 11'(50);
      bus.trex_y_pos  = 10'(93);
      bus.trex_width  = 10'(44);
      bus.trex_height = 10'(47);
   endtask

   task automatic do_reset();
      @(negedge clk);
      rst = 1'b1;
      repeat (2) @(negedge clk);
      rst = 1'b0;
   endtask

   // Pulse check, then watch 20 cycles; cycle n=1 is the one after check is sampled.
   task automatic run_scan(input int repulse_at, output int first_done,
                           output int n_done, output logic busy1);
      first_done = 0;
      n_done     = 0;
      busy1      = 1'b0;
      @(negedge clk);
      bus.check = 1'b1;
      @(negedge clk);
      bus.check = 1'b0;
      for (int n = 1; n <= 20; n++) begin
         if (n == 1) busy1 = bus.busy;
         if (bus.done) begin
            n_done++;
            if (first_done == 0) first_done = n;
         end
         bus.check = (n == repulse_at);
         @(negedge clk);
      end
      bus.check = 1'b0;
   endtask

   task automatic test_reset();
      do_reset();
      checks++; if (bus.busy !== 1'b0) begin errors++; $display("FAIL reset_busy got=%b exp=0", bus.busy); end
      checks++; if (bus.done !== 1'b0) begin errors++; $display("FAIL reset_done got=%b exp=0", bus.done); end
      checks++; if (bus.crash !== 1'b0) begin errors++; $display("FAIL reset_crash got=%b exp=0", bus.crash); end
      checks++; if (bus.hit_index !== 3'd0) begin errors++; $display("FAIL reset_hit_index got=%0d exp=0", bus.hit_index); end
   endtask

   task automatic test_hit_slot2();
      int fd, nd; logic b1;
      do_reset(); clear_slots(); set_trex();
      set_slot(2, 80, 105, 17, 35);
      run_scan(0, fd, nd, b1);
      checks++; if (b1 !== 1'b1) begin errors++; $display("FAIL hit2_busy got=%b exp=1", b1); end
      checks++; if (fd !== 4) begin errors++; $display("FAIL hit2_done_cycle got=%0d exp=4", fd); end
      checks++; if (nd !== 1) begin errors++; $display("FAIL hit2_done_count got=%0d exp=1", nd); end
      checks++; if (bus.crash !== 1'b1) begin errors++; $display("FAIL hit2_crash got=%b exp=1", bus.crash); end
      checks++; if (bus.hit_index !== 3'd2) begin errors++; $display("FAIL hit2_hit_index got=%0d exp=2", bus.hit_index); end
   endtask

   task automatic test_touching();
      int fd, nd; logic b1;
      do_reset(); clear_slots(); set_trex();
      set_slot(0, 92, 105, 17, 35);
      run_scan(0, fd, nd, b1);
      checks++; if (fd !== 8) begin errors++; $display("FAIL touch_done_cycle got=%0d exp=8", fd); end
      checks++; if (bus.crash !== 1'b0) begin errors++; $display("FAIL touch_crash got=%b exp=0", bus.crash); end
      set_slot(0, 91, 105, 17, 35);
      run_scan(0, fd, nd, b1);
      checks++; if (fd !== 2) begin errors++; $display("FAIL overlap1_done_cycle got=%0d exp=2", fd); end
      checks++; if (bus.crash !== 1'b1) begin errors++; $display("FAIL overlap1_crash got=%b exp=1", bus.crash); end
      checks++; if (bus.hit_index !== 3'd0) begin errors++; $display("FAIL overlap1_hit_index got=%0d exp=0", bus.hit_index); end
   endtask

   task automatic test_signed_x();
      int fd, nd; logic b1;
      do_reset(); clear_slots(); set_trex();
      set_slot(0, -20, 105, 17, 35);
      set_slot(6, 400, 105, 17, 35);
      run_scan(0, fd, nd, b1);
      checks++; if (fd !== 8) begin errors++; $display("FAIL negx_done_cycle got=%0d exp=8", fd); end
      checks++; if (bus.crash !== 1'b0) begin errors++; $display("FAIL negx_crash got=%b exp=0", bus.crash); end
      set_slot(6, 60, 105, 17, 35);
      run_scan(0, fd, nd, b1);
      checks++; if (fd !== 8) begin errors++; $display("FAIL slot6_done_cycle got=%0d exp=8", fd); end
      checks++; if (bus.crash !== 1'b1) begin errors++; $display("FAIL slot6_crash got=%b exp=1", bus.crash); end
      checks++; if (bus.hit_index !== 3'd6) begin errors++; $display("FAIL slot6_hit_index got=%0d exp=6", bus.hit_index); end
   endtask

   task automatic test_first_hit_sticky();
      int fd, nd; logic b1;
      do_reset(); clear_slots(); set_trex();
      set_slot(1, 80, 105, 17, 35);
      set_slot(4, 60, 100, 20, 20);
      run_scan(0, fd, nd, b1);
      checks++; if (fd !== 3) begin errors++; $display("FAIL first_done_cycle got=%0d exp=3", fd); end
      checks++; if (bus.hit_index !== 3'd1) begin errors++; $display("FAIL first_hit_index got=%0d exp=1", bus.hit_index); end
      clear_slots();
      set_slot(3, 400, 105, 17, 35);
      run_scan(0, fd, nd, b1);
      checks++; if (nd !== 0) begin errors++; $display("FAIL sticky_done_count got=%0d exp=0", nd); end
      checks++; if (b1 !== 1'b0) begin errors++; $display("FAIL sticky_busy got=%b exp=0", b1); end
      checks++; if (bus.crash !== 1'b1) begin errors++; $display("FAIL sticky_crash got=%b exp=1", bus.crash); end
      checks++; if (bus.hit_index !== 3'd1) begin errors++; $display("FAIL sticky_hit_index got=%0d exp=1", bus.hit_index); end
   endtask

   task automatic test_back_to_back();
      int fd, nd; logic b1;
      do_reset(); clear_slots(); set_trex();
      set_slot(5, 400, 105, 17, 35);
      run_scan(2, fd, nd, b1);
      checks++; if (nd !== 1) begin errors++; $display("FAIL repulse_done_count got=%0d exp=1", nd); end
      checks++; if (fd !== 8) begin errors++; $display("FAIL repulse_done_cycle got=%0d exp=8", fd); end
      set_slot(3, 60, 105, 2, 35);
      run_scan(0, fd, nd, b1);
      checks++; if (bus.crash !== 1'b0) begin errors++; $display("FAIL thin_crash got=%b exp=0", bus.crash); end
      checks++; if (fd !== 8) begin errors++; $display("FAIL thin_done_cycle got=%0d exp=8", fd); end
   endtask

   task automatic test_reset_mid_scan();
      int fd, nd, late_done; logic b1;
      do_reset(); clear_slots(); set_trex();
      @(negedge clk);
      bus.check = 1'b1;
      @(negedge clk);
      bus.check = 1'b0;
      repeat (3) @(negedge clk);
      checks++; if (bus.busy !== 1'b1) begin errors++; $display("FAIL mid_busy_before got=%b exp=1", bus.busy); end
      rst = 1'b1;
      @(negedge clk);
      rst = 1'b0;
      checks++; if (bus.busy !== 1'b0) begin errors++; $display("FAIL mid_busy got=%b exp=0", bus.busy); end
      checks++; if (bus.done !== 1'b0) begin errors++; $display("FAIL mid_done got=%b exp=0", bus.done); end
      checks++; if (bus.crash !== 1'b0) begin errors++; $display("FAIL mid_crash got=%b exp=0", bus.crash); end
      checks++; if (bus.hit_index !== 3'd0) begin errors++; $display("FAIL mid_hit_index got=%0d exp=0", bus.hit_index); end
      late_done = 0;
      for (int n = 0; n < 10; n++) begin
         if (bus.done) late_done++;
         @(negedge clk);
      end
      checks++; if (late_done !== 0) begin errors++; $display("FAIL mid_late_done got=%0d exp=0", late_done); end
      set_slot(2, 80, 105, 17, 35);
      run_scan(0, fd, nd, b1);
      checks++; if (fd !== 4) begin errors++; $display("FAIL post_rst_done_cycle got=%0d exp=4", fd); end
      checks++; if (bus.hit_index !== 3'd2) begin errors++; $display("FAIL post_rst_hit_index got=%0d exp=2", bus.hit_index); end
   endtask

   initial begin
      bus.check = 1'b0;
      clear_slots();
      set_trex();
      test_reset();
      test_hit_slot2();
      test_touching();
      test_signed_x();
      test_first_hit_sticky();
      test_back_to_back();
      test_reset_mid_scan();
      $display("Result: errors=%0d of %0d checks", errors, checks);
      $finish;
   end
endmodule
